split_mul_ctrl: RTL



---
 rtl/split_mul_ctrl_pkg.sv | 20 ++
 rtl/data_split.sv | 23 ++
 rtl/split_mul_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/split_mul_ctrl_pkg.sv
// Shared types and width helpers for the split-multiply controller.
package split_mul_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISS_H = 3'd1,
      S_ISS_L = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   function automatic int pw_f(input int mwh, input int cw);
      return mwh + cw;
   endfunction

   function automatic int rw_f(input int dw, input int cw);
      return dw + cw;
   endfunction

endpackage

// File: rtl/data_split.sv
// Splits each signed lane word (sign-extended by one bit) into a signed
// high part and an unsigned low part.
module data_split
   import split_mul_ctrl_pkg::*;
#(
   parameter int DN  = 6,
   parameter int DW  = 21,
   parameter int MWH = 18,
   parameter int MWL = 4
) (
   input  logic [DN*DW-1:0]  data_i,
   output logic [DN*MWH-1:0] hi_o,
   output logic [DN*MWL-1:0] lo_o
);

   for (genvar g = 0; g < DN; g++) begin : g_lane
      logic [DW:0] ext;
      assign ext                = {data_i[g*DW+DW-1], data_i[g*DW +: DW]};
      assign hi_o[g*MWH +: MWH] = ext[MWL +: MWH];
      assign lo_o[g*MWL +: MWL] = ext[MWL-1:0];
   end

endmodule

// File: rtl/split_mul_ctrl.sv
// Issues each vector to a narrow shared multiplier as a high pass then a
// low pass, and recombines the two products into full-width results.
module split_mul_ctrl
   import split_mul_ctrl_pkg::*;
#(
   parameter int DN  = 6,
   parameter int DW  = 21,
   parameter int MWH = 18,
   parameter int MWL = 4,
   parameter int CW  = 18,
   parameter int LAT = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DN*DW-1:0]          s_data,
   input  logic [DN*CW-1:0]          s_coef,
   output logic                      mul_valid,
   output logic [DN*MWH-1:0]         mul_a,
   output logic [DN*CW-1:0]          mul_b,
   output logic                      mul_tag,
   input  logic                      mul_res_valid,
   input  logic [DN*(MWH+CW)-1:0]    mul_res,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DN*(DW+CW)-1:0]     m_data,
   output logic                      err
);

   localparam int PW   = pw_f(MWH, CW);
   localparam int RW   = rw_f(DW, CW);
   localparam int CNTW = $clog2(LAT + 3);
   localparam logic [CNTW-1:0] HI_AT    = CNTW'(LAT + 1);
   localparam logic [CNTW-1:0] LO_AT    = CNTW'(LAT + 2);
   localparam logic [CNTW-1:0] IGN_INIT = CNTW'(LAT + 1);

   state_e              state_q, state_d;
   logic [CNTW-1:0]     cnt_q, ign_q;
   logic [DN*MWH-1:0]   hi_s, lo_ext, mul_a_q;
   logic [DN*MWL-1:0]   lo_s, lo_q;
   logic [DN*CW-1:0]    mul_b_q;
   logic [DN*PW-1:0]    hold_q;
   logic [DN*RW-1:0]    res_s, m_data_q;
   logic                mul_valid_q, mul_tag_q, m_valid_q, err_q;
   logic                busy, sched_hi, sched_lo, accept;

   data_split #(
      .DN  (DN),
      .DW  (DW),
      .MWH (MWH),
      .MWL (MWL)
   ) u_split (
      .data_i (s_data),
      .hi_o   (hi_s),
      .lo_o   (lo_s)
   );

   for (genvar g = 0; g < DN; g++) begin : g_lane
      logic [RW:0] hx, lx;
      assign lo_ext[g*MWH +: MWH] = {{(MWH-MWL){1'b0}}, lo_q[g*MWL +: MWL]};
      assign hx = {{MWL{hold_q[g*PW+PW-1]}}, hold_q[g*PW +: PW]};
      assign lx = {{MWL{mul_res[g*PW+PW-1]}}, mul_res[g*PW +: PW]};
      // The true product always fits RW bits, so dropping the top bit is exact.
      assign res_s[g*RW +: RW] = RW'((hx << MWL) + lx);
   end

   // Result slots are tracked by cycles since acceptance rather than by
   // state, since with LAT=1 the high product already returns in ISS_L.
   assign busy     = (state_q == S_ISS_H) || (state_q == S_ISS_L) || (state_q == S_WAIT);
   assign sched_hi = busy && (cnt_q == HI_AT);
   assign sched_lo = busy && (cnt_q == LO_AT);
   assign accept   = (state_q == S_IDLE) && s_valid;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (s_valid) state_d = S_ISS_H;
         S_ISS_H: state_d = S_ISS_L;
         S_ISS_L: state_d = S_WAIT;
         S_WAIT:  if (sched_lo) state_d = S_DONE;
         S_DONE:  if (m_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ign_q       <= IGN_INIT;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         lo_q        <= '0;
         hold_q      <= '0;
         m_data_q    <= '0;
         mul_valid_q <= 1'b0;
         mul_tag_q   <= 1'b0;
         m_valid_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ign_q != '0) ign_q <= ign_q - 1'b1;

         if (accept)                cnt_q <= CNTW'(1);
         else if (busy && !sched_lo) cnt_q <= cnt_q + 1'b1;
         else                       cnt_q <= '0;

         if (accept) begin
            mul_a_q     <= hi_s;
            mul_b_q     <= s_coef;
            lo_q        <= lo_s;
            mul_valid_q <= 1'b1;
            mul_tag_q   <= 1'b0;
         end else if (state_q == S_ISS_H) begin
            mul_a_q   <= lo_ext;
            mul_tag_q <= 1'b1;
         end else if (state_q == S_ISS_L) begin
            mul_valid_q <= 1'b0;
         end

         if (sched_hi) hold_q <= mul_res;

         if (sched_lo) begin
            m_data_q  <= res_s;
            m_valid_q <= 1'b1;
         end else if ((state_q == S_DONE) && m_ready) begin
            m_valid_q <= 1'b0;
         end

         // Stray results right after reset belong to an abandoned vector.
         if (mul_res_valid && !(sched_hi || sched_lo) && (ign_q == '0)) err_q <= 1'b1;
         if (!mul_res_valid && (sched_hi || sched_lo)) err_q <= 1'b1;
      end
   end

   assign s_ready   = (state_q == S_IDLE);
   assign mul_valid = mul_valid_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_tag   = mul_tag_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign err       = err_q;

endmodule
